point_test_sb_arbiter: RTL

- Shares the single sideband TX message port between the TX-initiated point-test requester (TX side, index 0) and the RX-side responder (index 1).
- Grants one requester at a time and latches its message and data.
- Drives the sideband serializer and holds the grant until the serializer's busy falls.
- Returns a one-cycle done pulse to the granted requester; this replaces the per-FSM busy-negedge/priority muxing.

---
 rtl/point_test_pkg.sv | 30 +++
 rtl/sb_busy_edge_det.sv | 23 ++
 rtl/point_test_sb_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/point_test_pkg.sv
// Shared types and constants for the point-test sideband arbitration logic.
package point_test_pkg;

    localparam int unsigned MSG_W  = 4;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        ISSUE          = 2'd1,
        WAIT_BUSY_FALL = 2'd2,
        GUARD          = 2'd3
    } state_e;

    localparam logic REQ_TX = 1'b0;
    localparam logic REQ_RX = 1'b1;

    // Sideband message codes exchanged by the point-test FSMs
    localparam logic [MSG_W-1:0] MSG_NOP      = 4'b0000;
    localparam logic [MSG_W-1:0] MSG_PT_REQ   = 4'b0001;
    localparam logic [MSG_W-1:0] MSG_PT_RESP  = 4'b0010;
    localparam logic [MSG_W-1:0] MSG_PT_START = 4'b0011;
    localparam logic [MSG_W-1:0] MSG_PT_DONE  = 4'b0100;
    localparam logic [MSG_W-1:0] MSG_PT_ERR   = 4'b1111;

    typedef struct packed {
        logic [MSG_W-1:0]  msg;
        logic [DATA_W-1:0] data;
    } sb_msg_t;

endpackage

// File: rtl/sb_busy_edge_det.sv
// Registers the serializer busy line and flags its rising and falling edges.
module sb_busy_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic i_busy,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= i_busy;
        end
    end

    assign o_rise_c = i_busy & ~busy_q;
    assign o_fall_c = ~i_busy & busy_q;

endmodule

// File: rtl/point_test_sb_arbiter.sv
// Arbitrates the single sideband TX port between the point-test TX requester
// and the RX responder, holding the grant until the serializer finishes.
module point_test_sb_arbiter
    import point_test_pkg::*;
#(
    parameter bit          RR_EN     = 1'b0,
    parameter int unsigned TIMEOUT_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_tx_valid,
    input  logic [MSG_W-1:0]  i_tx_encoded_msg,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_rx_valid,
    input  logic [MSG_W-1:0]  i_rx_encoded_msg,
    input  logic [DATA_W-1:0] i_rx_data,
    input  logic              i_sb_busy,
    output logic              o_sb_valid,
    output logic [MSG_W-1:0]  o_sb_encoded_msg,
    output logic [DATA_W-1:0] o_sb_data,
    output logic              o_sb_src,
    output logic              o_tx_done,
    output logic              o_rx_done,
    output logic              o_timeout
);

    // Abort fires on the edge that moves the counter onto all-ones
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = ~TIMEOUT_W'(1);

    state_e                 state_q, state_d;
    sb_msg_t                payload_q, payload_d;
    logic                   src_q, src_d;
    logic                   sb_valid_q, sb_valid_d;
    logic                   tx_done_q, tx_done_d;
    logic                   rx_done_q, rx_done_d;
    logic                   timeout_q, timeout_d;
    logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
    logic                   rr_ptr_q, rr_ptr_d;
    logic                   win;
    logic                   busy_rise, busy_fall;
    logic                   issue_start;

    sb_busy_edge_det u_busy_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_busy   (i_sb_busy),
        .o_rise_c (busy_rise),
        .o_fall_c (busy_fall)
    );

    // A fresh rise, or busy already high when ISSUE is entered, both start the transfer
    assign issue_start = busy_rise | i_sb_busy;

    always_comb begin
        state_d    = state_q;
        payload_d  = payload_q;
        src_d      = src_q;
        sb_valid_d = sb_valid_q;
        tx_done_d  = 1'b0;
        rx_done_d  = 1'b0;
        timeout_d  = 1'b0;
        cnt_d      = cnt_q;
        rr_ptr_d   = rr_ptr_q;

        win = REQ_TX;
        if (i_tx_valid && i_rx_valid) begin
            win = RR_EN ? rr_ptr_q : REQ_TX;
        end else if (i_rx_valid) begin
            win = REQ_RX;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (i_tx_valid || i_rx_valid) begin
                    src_d          = win;
                    payload_d.msg  = (win == REQ_RX) ? i_rx_encoded_msg : i_tx_encoded_msg;
                    payload_d.data = (win == REQ_RX) ? i_rx_data : i_tx_data;
                    sb_valid_d     = 1'b1;
                    state_d        = ISSUE;
                    if (RR_EN && i_tx_valid && i_rx_valid) begin
                        rr_ptr_d = ~win;
                    end
                end
            end
            ISSUE, WAIT_BUSY_FALL: begin
                cnt_d = cnt_q + TIMEOUT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    timeout_d  = 1'b1;
                    sb_valid_d = 1'b0;
                    state_d    = IDLE;
                end else if (state_q == ISSUE) begin
                    if (issue_start) begin
                        sb_valid_d = 1'b0;
                        state_d    = WAIT_BUSY_FALL;
                    end
                end else if (busy_fall) begin
                    tx_done_d = (src_q == REQ_TX);
                    rx_done_d = (src_q == REQ_RX);
                    state_d   = GUARD;
                end
            end
            GUARD: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            payload_q  <= '0;
            src_q      <= REQ_TX;
            sb_valid_q <= 1'b0;
            tx_done_q  <= 1'b0;
            rx_done_q  <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
            rr_ptr_q   <= REQ_TX;
        end else begin
            state_q    <= state_d;
            payload_q  <= payload_d;
            src_q      <= src_d;
            sb_valid_q <= sb_valid_d;
            tx_done_q  <= tx_done_d;
            rx_done_q  <= rx_done_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign o_sb_valid       = sb_valid_q;
    assign o_sb_encoded_msg = payload_q.msg;
    assign o_sb_data        = payload_q.data;
    assign o_sb_src         = src_q;
    assign o_tx_done        = tx_done_q;
    assign o_rx_done        = rx_done_q;
    assign o_timeout        = timeout_q;

endmodule
